// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED sequencer: mode and state encodings, the
// sweep direction, the default 20 MHz timing constants and a helper that
// sizes counters.
// ---------------------------------------------------------------------------
package led_pkg;

    // Sequencing modes as presented on the mode input.
    typedef enum logic [1:0] {
        MODE_FWD = 2'd0,
        MODE_REV = 2'd1,
        MODE_PP  = 2'd2,
        MODE_ALL = 2'd3
    } mode_t;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Ping-pong sweep direction.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Default timing at a 20 MHz clock, in clock cycles.
    localparam int unsigned T100MS = 2_000_000;
    localparam int unsigned T50MS  = 1_000_000;
    localparam int unsigned T75MS  = 1_500_000;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_slot_timer.sv
// ---------------------------------------------------------------------------
// led_slot_timer
// Slot counter shared by all LEDs. Counts 0..T_SLOT-1 while enabled and wraps.
//   CLK   in   system clock, rising edge
//   RST_n in   synchronous active-low reset
//   clr   in   force the count to zero (wins over en)
//   en    in   advance the count
//   cnt   out  current count
//   tick  out  high in the last cycle of a slot while enabled
// ---------------------------------------------------------------------------
module led_slot_timer
    import led_pkg::*;
#(
    parameter int unsigned T_SLOT = T100MS,
    parameter int unsigned CW     = cnt_width(T_SLOT)
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tick
);

    localparam logic [CW-1:0] CNT_LAST = CW'(T_SLOT - 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    assign tick = en && (cnt_reg == CNT_LAST);
    assign cnt  = cnt_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (tick) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl
// Shares one slot timer across NUM_LED outputs, lighting one LED per slot in
// forward, reverse or ping-pong order, or all LEDs together. Each lit LED is
// on for slot counts ON_START..ON_END-1, seen one cycle later on LED_Out.
//   CLK     in   system clock, rising edge
//   RST_n   in   synchronous active-low reset
//   start   in   single-cycle start request (honoured only in IDLE)
//   stop    in   single-cycle abort request (wins over start)
//   mode    in   0 fwd, 1 rev, 2 ping-pong, 3 all-together
//   LED_Out out  registered LED drive, active high
//   busy    out  high while running
//   done    out  one-cycle pulse after ROUNDS rounds (never when ROUNDS==0)
// ---------------------------------------------------------------------------
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int unsigned NUM_LED  = 4,
    parameter int unsigned T_SLOT   = T100MS,
    parameter int unsigned ON_START = T50MS,
    parameter int unsigned ON_END   = T75MS,
    parameter int unsigned ROUNDS   = 0
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    output logic [NUM_LED-1:0] LED_Out,
    output logic               busy,
    output logic               done
);

    localparam int unsigned   CW       = cnt_width(T_SLOT);
    localparam int unsigned   IW       = cnt_width(NUM_LED);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_LED - 1);
    // Index reached when turning at the top of a ping-pong sweep.
    localparam logic [IW-1:0] IDX_TURN = IW'(NUM_LED - 2);
    localparam logic [15:0]   ROUNDS_Q = 16'(ROUNDS);

    state_t             state_reg, state_next;
    logic [IW-1:0]      idx_reg, idx_next;
    dir_t               dir_reg, dir_next;
    logic [15:0]        round_reg, round_next;
    mode_t              mode_reg, mode_next;
    logic [NUM_LED-1:0] led_reg, led_next;

    logic [CW-1:0]      slot_cnt;
    logic               slot_tick;
    logic               timer_clr;
    logic               timer_en;
    logic               in_window;
    logic [NUM_LED-1:0] led_hit;

    logic [IW-1:0]      step_idx;
    dir_t               step_dir;
    logic               step_wrap;

    led_slot_timer #(
        .T_SLOT (T_SLOT),
        .CW     (CW)
    ) u_timer (
        .CLK   (CLK),
        .RST_n (RST_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .cnt   (slot_cnt),
        .tick  (slot_tick)
    );

    // Compare in 32 bits: ON_END may equal T_SLOT, which need not fit in CW.
    assign in_window = (32'(slot_cnt) >= ON_START) && (32'(slot_cnt) < ON_END);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LED; gi++) begin : g_hit
            assign led_hit[gi] = in_window &&
                                 ((idx_reg == IW'(gi)) || (mode_reg == MODE_ALL));
        end
    endgenerate

    // Index that follows the current one, and whether that step closes a round.
    always_comb begin
        step_idx  = idx_reg;
        step_dir  = dir_reg;
        step_wrap = 1'b0;
        case (mode_reg)
            MODE_FWD: begin
                step_wrap = (idx_reg == IDX_LAST);
                step_idx  = step_wrap ? '0 : idx_reg + IW'(1);
            end
            MODE_REV: begin
                step_wrap = (idx_reg == '0);
                step_idx  = step_wrap ? IDX_LAST : idx_reg - IW'(1);
            end
            MODE_PP: begin
                if (dir_reg == DIR_UP) begin
                    if (idx_reg == IDX_LAST) begin
                        step_idx = IDX_TURN;
                        step_dir = DIR_DOWN;
                    end else begin
                        step_idx = idx_reg + IW'(1);
                    end
                end else begin
                    step_idx = idx_reg - IW'(1);
                end
                // Landing on 0 ends the sweep; with two LEDs that already
                // happens at the top turn, so the direction stays up.
                if (step_idx == '0) begin
                    step_wrap = 1'b1;
                    step_dir  = DIR_UP;
                end
            end
            default: begin
                step_wrap = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        dir_next   = dir_reg;
        round_next = round_reg;
        mode_next  = mode_reg;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;
        busy       = (state_reg == RUN);
        done       = (state_reg == FINISH);

        case (state_reg)
            IDLE: begin
                timer_clr = 1'b1;
                if (start && !stop) begin
                    mode_next  = mode_t'(mode);
                    idx_next   = (mode_t'(mode) == MODE_REV) ? IDX_LAST : '0;
                    dir_next   = DIR_UP;
                    round_next = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    timer_clr  = 1'b1;
                    state_next = IDLE;
                end else begin
                    timer_en = 1'b1;
                    if (slot_tick) begin
                        idx_next = step_idx;
                        dir_next = step_dir;
                        if (step_wrap) begin
                            round_next = round_reg + 16'd1;
                            if ((ROUNDS != 0) && (round_next == ROUNDS_Q)) begin
                                state_next = FINISH;
                            end
                        end
                    end
                end
            end
            default: begin
                timer_clr  = 1'b1;
                state_next = IDLE;
            end
        endcase

        // Lit only when both this cycle and the next are RUN, so leaving RUN
        // (stop or completion) darkens the outputs on that same edge.
        led_next = ((state_reg == RUN) && (state_next == RUN)) ? led_hit : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            idx_reg   <= '0;
            dir_reg   <= DIR_UP;
            round_reg <= '0;
            mode_reg  <= MODE_FWD;
            led_reg   <= '0;
        end else begin
            idx_reg   <= idx_next;
            dir_reg   <= dir_next;
            round_reg <= round_next;
            mode_reg  <= mode_next;
            led_reg   <= led_next;
        end
    end

    assign LED_Out = led_reg;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_seq_ctrl
// Self-checking bench for led_seq_ctrl with NUM_LED=4, T_SLOT=20, ON_START=5,
// ON_END=15. One instance stops after 2 rounds, a second free-runs.
// ---------------------------------------------------------------------------
module tb_led_seq_ctrl;

    localparam int TS  = 20;
    localparam int ONS = 5;
    localparam int ONE = 15;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic       start, stop;
    logic [1:0] mode;
    logic [3:0] LED_Out;
    logic       busy, done;

    logic       start_f, stop_f;
    logic [1:0] mode_f;
    logic [3:0] led_f;
    logic       busy_f, done_f;

    always #5 CLK = ~CLK;

    led_seq_ctrl #(
        .NUM_LED (4), .T_SLOT (TS), .ON_START (ONS), .ON_END (ONE), .ROUNDS (2)
    ) dut (
        .CLK (CLK), .RST_n (RST_n), .start (start), .stop (stop), .mode (mode),
        .LED_Out (LED_Out), .busy (busy), .done (done)
    );

    led_seq_ctrl #(
        .NUM_LED (4), .T_SLOT (TS), .ON_START (ONS), .ON_END (ONE), .ROUNDS (0)
    ) dut_free (
        .CLK (CLK), .RST_n (RST_n), .start (start_f), .stop (stop_f), .mode (mode_f),
        .LED_Out (led_f), .busy (busy_f), .done (done_f)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  mode;
        int          nslots;
        logic [47:0] pats;     // expected LED pattern per slot, slot 0 in low nibble
        bit          disturb;  // pulse start and change mode mid-run
        string       name;
    } scen_t;

    scen_t scen[4];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // act/exp are {LED, busy, done}
    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: LED=%b busy=%b done=%b, expected LED=%b busy=%b done=%b",
                     nm, $time, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic run_scen(input scen_t sc);
        int total;
        int c;
        int s;
        logic [3:0] el;
        total = sc.nslots * TS;
        start = 1'b1;
        mode  = sc.mode;
        tick();
        start = 1'b0;
        chk({sc.name, "_start"}, {LED_Out, busy, done}, {4'b0000, 1'b1, 1'b0});
        for (int t = 1; t <= total + 1; t++) begin
            if (sc.disturb && t == 31) begin
                start = 1'b1;
                mode  = ~sc.mode;
            end else begin
                start = 1'b0;
            end
            tick();
            if (t < total) begin
                c  = (t - 1) % TS;
                s  = (t - 1) / TS;
                el = (c >= ONS && c < ONE) ? sc.pats[s*4 +: 4] : 4'b0000;
                chk(sc.name, {LED_Out, busy, done}, {el, 1'b1, 1'b0});
            end else if (t == total) begin
                chk({sc.name, "_done"}, {LED_Out, busy, done}, {4'b0000, 1'b0, 1'b1});
            end else begin
                chk({sc.name, "_idle"}, {LED_Out, busy, done}, {4'b0000, 1'b0, 1'b0});
            end
        end
        mode = 2'd0;
        $display("scenario %s: mode=%0d slots=%0d checked", sc.name, sc.mode, sc.nslots);
    endtask

    initial begin
        int c;
        int s;
        logic [3:0] el;

        scen[0] = '{2'd0, 8,  48'h0000_8421_8421, 1'b0, "fwd"};
        scen[1] = '{2'd2, 12, 48'h2484_2124_8421, 1'b0, "pingpong"};
        scen[2] = '{2'd1, 8,  48'h0000_1248_1248, 1'b1, "rev_conflict"};
        scen[3] = '{2'd3, 2,  48'h0000_0000_00FF, 1'b0, "all"};

        RST_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
        start_f = 1'b0; stop_f = 1'b0; mode_f = 2'd0;

        // Reset state
        tick();
        tick();
        chk("reset", {LED_Out, busy, done}, 6'b0);
        chk("reset_free", {led_f, busy_f, done_f}, 6'b0);
        RST_n = 1'b1;
        tick();
        chk("post_reset", {LED_Out, busy, done}, 6'b0);
        $display("sequence reset: outputs idle");

        // Start and stop together in IDLE: stays idle
        start = 1'b1; stop = 1'b1; mode = 2'd3;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", {LED_Out, busy, done}, 6'b0);
        for (int i = 0; i < 8; i++) tick();
        chk("start_stop_idle_late", {LED_Out, busy, done}, 6'b0);
        $display("sequence start+stop in IDLE: no run");

        // Table-driven full runs
        for (int k = 0; k < 4; k++) begin
            run_scen(scen[k]);
            tick();
        end

        // Mid-run stop in mode 3 at slot_cnt 8, then fresh start
        start = 1'b1; mode = 2'd3;
        tick();
        start = 1'b0;
        for (int t = 1; t <= 8; t++) tick();
        chk("stop_before", {LED_Out, busy, done}, {4'b1111, 1'b1, 1'b0});
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_edge", {LED_Out, busy, done}, 6'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stop_no_done", {LED_Out, busy, done}, 6'b0);
        end
        start = 1'b1; mode = 2'd3;
        tick();
        start = 1'b0;
        for (int t = 1; t <= 5; t++) tick();
        chk("restart_dark", {LED_Out, busy, done}, {4'b0000, 1'b1, 1'b0});
        tick();
        chk("restart_lit", {LED_Out, busy, done}, {4'b1111, 1'b1, 1'b0});
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("restart_stop", {LED_Out, busy, done}, 6'b0);
        $display("sequence mid-run stop and restart");

        // Synchronous reset mid-slot while LED 2 lit
        start = 1'b1; mode = 2'd0;
        tick();
        start = 1'b0;
        for (int t = 1; t <= 50; t++) tick();
        chk("rst_before", {LED_Out, busy, done}, {4'b0100, 1'b1, 1'b0});
        RST_n = 1'b0;
        @(negedge CLK);
        chk("rst_hold_no_edge", {LED_Out, busy, done}, {4'b0100, 1'b1, 1'b0});
        @(posedge CLK);
        #1;
        chk("rst_edge", {LED_Out, busy, done}, 6'b0);
        RST_n = 1'b1;
        tick();
        chk("rst_after", {LED_Out, busy, done}, 6'b0);
        $display("sequence sync reset mid-run");

        // Free-run reverse on the ROUNDS=0 instance for 11 rounds
        start_f = 1'b1; mode_f = 2'd1;
        tick();
        start_f = 1'b0;
        chk("free_start", {led_f, busy_f, done_f}, {4'b0000, 1'b1, 1'b0});
        for (int t = 1; t <= 11 * 4 * TS; t++) begin
            tick();
            c  = (t - 1) % TS;
            s  = (t - 1) / TS;
            el = (c >= ONS && c < ONE) ? (4'b1000 >> (s % 4)) : 4'b0000;
            chk("free_run", {led_f, busy_f, done_f}, {el, 1'b1, 1'b0});
        end
        stop_f = 1'b1;
        tick();
        stop_f = 1'b0;
        chk("free_stop", {led_f, busy_f, done_f}, 6'b0);
        $display("sequence free-run reverse 11 rounds");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
